axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
Synthesizable AXI4-Lite initiator. It converts single-beat commands from a simple valid/ready command port into AXI4-Lite write or read transactions, and returns one response per command. It is the RTL counterpart of the bench master agent: it lets on-chip logic drive axi_lite_template and other AXI4-Lite slaves. One outstanding transaction at a time.

Parameters:
- DATA_WIDTH, 32, AXI data width (32 or 64).
- ADDR_WIDTH, 32, AXI address width.
- AXI_PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid&&rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes).
- rsp_resp  out  2  bresp/rresp captured.
- awaddr/awprot/awvalid out, awready in: AW channel (ADDR_WIDTH/3/1/1).
- wdata/wstrb/wvalid out, wready in: W channel (DATA_WIDTH/DATA_WIDTH/8/1/1).
- bresp in 2, bvalid in 1, bready out 1: B channel.
- araddr/arprot/arvalid out, arready in: AR channel (ADDR_WIDTH/3/1/1).
- rdata in DATA_WIDTH, rresp in 2, rvalid in 1, rready out 1: R channel.

Behaviour:
- Reset (async, any state): FSM to IDLE. All valid/ready outputs 0 except cmd_ready=1. Address, data, strobe and rsp_* outputs 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On accept, latch addr/wdata/wstrb/write. Next cycle: WR_REQ with awvalid=wvalid=1, or RD_REQ with arvalid=1. All AXI outputs are registered.
- WR_REQ: AW and W complete independently. awvalid drops the cycle after awready; wvalid drops the cycle after wready. Both may complete in the same cycle. Once both are done, go to WR_RESP.
- WR_RESP: bready=1. On bvalid, capture bresp and go to RSP.
- RD_REQ: arvalid held until arready, then go to RD_RESP.
- RD_RESP: rready=1. On rvalid, capture rdata/rresp and go to RSP.
- RSP: rsp_valid=1; rsp_* held stable until rsp_ready, then go to IDLE. cmd_ready=0 in every state except IDLE.
- Minimum latency, zero-wait slave: cmd accept at cycle N; AW/W or AR handshake at N+1; B/R at N+2; rsp_valid at N+3. Next command accepted at N+4 with rsp_ready=1.
- AXI rules: valid never depends combinationally on ready. Address, data and strobe are stable while valid is high. Valid is never withdrawn before its handshake.
- No timeout: a non-responding slave stalls the block until rst.
- Non-OKAY responses (SLVERR/DECERR) are passed through unchanged; the transaction still completes normally.
- cmd_addr is used verbatim; no alignment check or masking.

Optional Feature:
- Macro AXIL_ERR_STATUS_EN.
- Defined: adds outputs err_sticky (1 bit) and err_count (16 bits), both reset to 0. At each B/R capture with resp!=OKAY, err_sticky is set and err_count increments, saturating at 16'hFFFF. Input err_clear (1 bit) zeroes both. If err_clear coincides with an error capture, clear wins.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package axi_lite_pkg: resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), master FSM state enum, and a default prot constant.
- No sub-module. Single module with one FSM plus AW-done/W-done flags.

Test Plan:
- Write then read back against axi_lite_template: write 32'hDEADBEEF to 0x10 with wstrb 4'hF, then read 0x10 -> rsp_rdata=32'hDEADBEEF, rsp_resp=OKAY, rsp_write=0.
- Skewed write handshake, slave model with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, exactly one B accepted, one response.
- Partial strobe: write 32'h11223344 with wstrb 4'b0101 over a prior 0 -> readback 32'h00220044.
- Response backpressure: rsp_ready low 5 cycles -> rsp_* stable, cmd_ready=0, no new AW/AR issued.
- Error response: slave returns rresp=SLVERR, rdata=0xBAD -> rsp_resp=2'b10. With AXIL_ERR_STATUS_EN: err_sticky=1, err_count=1; err_clear -> both 0.
- Reset mid-transaction: assert rst while in WR_RESP -> all AXI valids/readies 0 immediately, cmd_ready=1 after release, next read completes correctly.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the command master.
// Response codes, master FSM states, default prot.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
// master drives requests, slave drives readies and responses.
interface axi_lite_cmd_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite initiator fed by a cmd/rsp port.
// Optional error status block: define AXIL_ERR_STATUS_EN.
module axi_lite_cmd_master
  import axi_lite_pkg::*;
#(
  parameter int         DATA_WIDTH = 32,
  parameter int         ADDR_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = PROT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
`ifdef AXIL_ERR_STATUS_EN
  input  logic                    err_clear,
  output logic                    err_sticky,
  output logic [15:0]             err_count,
`endif
  axi_lite_cmd_master_if.master   axi
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_t              state_q, state_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  resp_t               rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q & axi.wready;
  assign ar_hs = arvalid_q & axi.arready;
  assign b_hs  = bready_q & axi.bvalid;
  assign r_hs  = rready_q & axi.rvalid;

  // next-state and next registered outputs for the transaction FSM
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = resp_t'(axi.bresp);
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          state_d   = RD_RESP;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_RESP: begin
        if (r_hs) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = axi.rdata;
          rsp_resp_d  = resp_t'(axi.rresp);
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // state and every bus-facing output live in flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= OKAY;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_write   = rsp_write_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign axi.awaddr  = addr_q;
  assign axi.awprot  = AXI_PROT;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = AXI_PROT;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

`ifdef AXIL_ERR_STATUS_EN
  logic        err_hit;
  logic        err_sticky_q;
  logic [15:0] err_count_q;

  assign err_hit = (b_hs && (axi.bresp != OKAY))
                || (r_hs && (axi.rresp != OKAY));

  // sticky flag plus saturating count; clear beats a same-cycle error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else if (err_clear) begin
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else if (err_hit) begin
      err_sticky_q <= 1'b1;
      if (err_count_q != 16'hFFFF)
        err_count_q <= err_count_q + 16'd1;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed + randomized bench for axi_lite_cmd_master.
// Slave model with per-channel delays, memory reference model.
module tb_axi_lite_cmd_master;
  import axi_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
`ifdef AXIL_ERR_STATUS_EN
  logic          err_clear, err_sticky;
  logic [15:0]   err_count;
`endif

  always #5 clk = ~clk;

  axi_lite_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
`ifdef AXIL_ERR_STATUS_EN
    .err_clear(err_clear),
    .err_sticky(err_sticky),
    .err_count(err_count),
`endif
    .axi(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave configuration and observation
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic aw_pend, w_pend, ar_pend, b_drop, r_drop;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int b_hs_cnt = 0, aw_hi = 0, w_hi = 0, proto_err = 0;
  logic p_aw_wait, p_w_wait, p_ar_wait;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int last_lat, last_acc, exp_errs = 0;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  // test slave address map: 0x2xxx slave error, 0x3xxx decode error
  function automatic logic [1:0] region_resp(input logic [31:0] a);
    case (a[15:12])
      4'h2:    return 2'b10;
      4'h3:    return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    logic [31:0] v;
    v = ref_read(a);
    for (int i = 0; i < 4; i++)
      if (s[i]) v[8*i +: 8] = d[8*i +: 8];
    ref_mem[a >> 2] = v;
  endtask

  // slave: decisions at negedge, handshakes land on the next posedge
  initial begin : slave
    logic [31:0] k, v;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0; b_drop = 0; r_drop = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
    p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_wstrb = 0;
    s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.bvalid = 0; bus.rvalid = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; b_drop = 0; r_drop = 0;
        bus.awready = (aw_dly == 0); bus.wready = (w_dly == 0);
        bus.arready = (ar_dly == 0);
        aw_cnt = aw_dly; w_cnt = w_dly; ar_cnt = ar_dly;
        p_aw_wait = 0; p_w_wait = 0; p_ar_wait = 0;
      end else begin
        if (b_drop) begin bus.bvalid = 0; b_drop = 0; end
        if (aw_pend && w_pend && !bus.bvalid) begin
          if (b_cnt == 0) begin
            bus.bvalid = 1;
            bus.bresp = region_resp(s_awaddr);
            if (bus.bresp == 2'b00) begin
              k = s_awaddr >> 2;
              v = smem.exists(k) ? smem[k] : 32'h0;
              for (int i = 0; i < 4; i++)
                if (s_wstrb[i]) v[8*i +: 8] = s_wdata[8*i +: 8];
              smem[k] = v;
            end
            aw_pend = 0; w_pend = 0;
          end else b_cnt--;
        end
        if (bus.bvalid && bus.bready) begin b_hs_cnt++; b_drop = 1; end

        if (r_drop) begin bus.rvalid = 0; r_drop = 0; end
        if (ar_pend && !bus.rvalid) begin
          if (r_cnt == 0) begin
            bus.rvalid = 1;
            bus.rresp = region_resp(s_araddr);
            k = s_araddr >> 2;
            if (bus.rresp != 2'b00) bus.rdata = 32'hBAD;
            else bus.rdata = smem.exists(k) ? smem[k] : 32'h0;
            ar_pend = 0;
          end else r_cnt--;
        end
        if (bus.rvalid && bus.rready) r_drop = 1;

        if (!bus.awvalid) begin
          bus.awready = (aw_dly == 0); aw_cnt = aw_dly;
        end else if (!bus.awready) begin
          if (aw_cnt == 0) bus.awready = 1; else aw_cnt--;
        end
        if (bus.awvalid && bus.awready) begin
          if (aw_pend) proto_err++;
          aw_pend = 1; s_awaddr = bus.awaddr; b_cnt = b_dly;
        end

        if (!bus.wvalid) begin
          bus.wready = (w_dly == 0); w_cnt = w_dly;
        end else if (!bus.wready) begin
          if (w_cnt == 0) bus.wready = 1; else w_cnt--;
        end
        if (bus.wvalid && bus.wready) begin
          if (w_pend) proto_err++;
          w_pend = 1; s_wdata = bus.wdata; s_wstrb = bus.wstrb;
        end

        if (!bus.arvalid) begin
          bus.arready = (ar_dly == 0); ar_cnt = ar_dly;
        end else if (!bus.arready) begin
          if (ar_cnt == 0) bus.arready = 1; else ar_cnt--;
        end
        if (bus.arvalid && bus.arready) begin
          if (ar_pend) proto_err++;
          ar_pend = 1; s_araddr = bus.araddr; r_cnt = r_dly;
        end

        if (bus.awvalid) aw_hi++;
        if (bus.wvalid) w_hi++;
        if (p_aw_wait && (!bus.awvalid || bus.awaddr !== p_awaddr))
          proto_err++;
        if (p_w_wait && (!bus.wvalid || bus.wdata !== p_wdata
                         || bus.wstrb !== p_wstrb))
          proto_err++;
        if (p_ar_wait && (!bus.arvalid || bus.araddr !== p_araddr))
          proto_err++;
        p_aw_wait = bus.awvalid && !bus.awready;
        p_w_wait  = bus.wvalid && !bus.wready;
        p_ar_wait = bus.arvalid && !bus.arready;
        p_awaddr = bus.awaddr; p_wdata = bus.wdata;
        p_wstrb = bus.wstrb; p_araddr = bus.araddr;
      end
    end
  end

  // one command end to end; called and returns at #1 after a posedge
  task automatic do_cmd(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input int stall, input string tag);
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [35:0] held;
    int n;
    e_resp = region_resp(a);
    if (w) begin
      e_rdata = 32'h0;
      if (e_resp == 2'b00) ref_write(a, d, s);
    end else begin
      e_rdata = (e_resp == 2'b00) ? ref_read(a) : 32'hBAD;
    end
`ifdef AXIL_ERR_STATUS_EN
    if (err_clear) exp_errs = 0;
    else if (e_resp != 2'b00) exp_errs++;
`endif
    rsp_ready = (stall == 0);
    cmd_valid = 1; cmd_write = w; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, cmd_ready, 1);
    last_acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    last_lat = cyc - last_acc;
    chk({tag, "_rsp_write"}, rsp_write, w);
    chk({tag, "_rsp_rdata"}, rsp_rdata, e_rdata);
    chk({tag, "_rsp_resp"}, rsp_resp, e_resp);
    last_rdata = rsp_rdata;
    last_resp = rsp_resp;
    held = {rsp_write, rsp_resp, rsp_rdata, rsp_valid};
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk({tag, "_rsp_hold"},
          {rsp_write, rsp_resp, rsp_rdata, rsp_valid}, held);
      chk({tag, "_bp_idle"},
          {cmd_ready, bus.awvalid, bus.wvalid, bus.arvalid}, 4'b0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
`ifdef AXIL_ERR_STATUS_EN
    chk({tag, "_err_count"}, err_count, exp_errs);
    chk({tag, "_err_sticky"}, err_sticky, exp_errs != 0);
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int acc0, b0, n;
    logic        w;
    logic [31:0] a;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
`ifdef AXIL_ERR_STATUS_EN
    err_clear = 0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_valids",
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
         bus.rready, rsp_valid}, 6'b0);
    chk("reset_bus",
        {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 100'b0);
    chk("reset_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'b0);
`ifdef AXIL_ERR_STATUS_EN
    chk("reset_err", {err_sticky, err_count}, 17'b0);
`endif
    rst = 0;
    @(posedge clk); #1;

    do_cmd(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "wr10");
    chk("wr10_latency", last_lat, 3);
    acc0 = last_acc;
    do_cmd(0, 32'h10, 0, 0, 0, "rd10");
    chk("rd10_latency", last_lat, 3);
    chk("b2b_accept_gap", last_acc - acc0, 4);
    chk("rd10_data", last_rdata, 32'hDEADBEEF);

    aw_dly = 3; aw_hi = 0; w_hi = 0; b0 = b_hs_cnt;
    do_cmd(1, 32'h14, 32'hCAFE0001, 4'hF, 0, "skew");
    chk("skew_aw_cycles", aw_hi, 4);
    chk("skew_w_cycles", w_hi, 1);
    chk("skew_b_count", b_hs_cnt - b0, 1);
    aw_dly = 0;

    do_cmd(1, 32'h18, 32'h0, 4'hF, 0, "pz");
    do_cmd(1, 32'h18, 32'h11223344, 4'b0101, 0, "pw");
    do_cmd(0, 32'h18, 0, 0, 0, "pr");
    chk("partial_data", last_rdata, 32'h00220044);

    do_cmd(0, 32'h10, 0, 0, 5, "bp");

    do_cmd(0, 32'h2000, 0, 0, 0, "err_rd");
    chk("err_rd_resp", last_resp, 2'b10);
    chk("err_rd_data", last_rdata, 32'hBAD);
`ifdef AXIL_ERR_STATUS_EN
    chk("err_sticky_set", err_sticky, 1);
    chk("err_count_one", err_count, 1);
    err_clear = 1;
    @(posedge clk); #1;
    err_clear = 0;
    exp_errs = 0;
    chk("err_clear", {err_sticky, err_count}, 17'b0);
    err_clear = 1;
    do_cmd(0, 32'h3000, 0, 0, 0, "clr_wins");
    err_clear = 0;
`endif

    b_dly = 10;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h1C;
    cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0;
    n = 0;
    @(negedge clk);
    while (!bus.bready && n < 50) begin @(negedge clk); n++; end
    chk("mid_in_wr_resp", bus.bready, 1);
    #2 rst = 1;
    #1;
    chk("mid_rst_idle",
        {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready,
         bus.rready, rsp_valid}, 6'b0);
    repeat (2) @(negedge clk);
    b_dly = 0;
    rst = 0;
`ifdef AXIL_ERR_STATUS_EN
    exp_errs = 0;
`endif
    @(posedge clk); #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    do_cmd(0, 32'h10, 0, 0, 0, "post_rst_rd");
    chk("post_rst_data", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      b_dly = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = {16'h0, 4'($urandom_range(2, 3)), 12'h0};
      else
        a = 32'($urandom_range(0, 7)) << 2;
      do_cmd(w, a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), "rand");
    end

    chk("protocol_violations", proto_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
